// File: rtl/debug_cmd_dispatcher.sv
// Top-level debugger command sequencer: decodes host command bytes, runs one sub-FSM
// at a time, routes RX bytes to it and answers the host with a single ACK/NAK byte.
module debug_cmd_dispatcher #(
  parameter logic [7:0] CMD_LOAD       = 8'h4C,
  parameter logic [7:0] CMD_RUN        = 8'h52,
  parameter logic [7:0] CMD_STEP       = 8'h53,
  parameter logic [7:0] ACK_BYTE       = 8'hAA,
  parameter logic [7:0] NAK_BYTE       = 8'hEE,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         TO_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_rx_data,
  input  logic       is_rx_done,
  input  logic       is_load_done,
  input  logic       is_run_done,
  input  logic       is_step_done,
  input  logic       is_tx_done,
  output logic       os_start_load,
  output logic       os_start_run,
  output logic       os_start_step,
  output logic       os_abort,
  output logic [1:0] o_rx_owner,
  output logic       os_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_busy,
  output logic       o_prog_loaded,
  output logic       o_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOAD,
    S_WAIT_RUN,
    S_WAIT_STEP,
    S_SEND,
    S_WAIT_TX
  } state_t;

  localparam logic [1:0] OWN_DISP = 2'd0;
  localparam logic [1:0] OWN_LOAD = 2'd1;
  localparam logic [1:0] OWN_STEP = 2'd2;

  // The abort is registered, so it is decided one count early; it then appears in the
  // same cycle the counter would have reached TIMEOUT_CYCLES-1.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);

  state_t          r_state, w_state_next;
  logic            r_start_load, w_start_load_next;
  logic            r_start_run, w_start_run_next;
  logic            r_start_step, w_start_step_next;
  logic            r_abort, w_abort_next;
  logic            r_tx_start, w_tx_start_next;
  logic [1:0]      r_rx_owner, w_rx_owner_next;
  logic [7:0]      r_tx_data, w_tx_data_next;
  logic            r_prog_loaded, w_prog_loaded_next;
  logic            r_timeout, w_timeout_next;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_next;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_start_load  <= 1'b0;
      r_start_run   <= 1'b0;
      r_start_step  <= 1'b0;
      r_abort       <= 1'b0;
      r_tx_start    <= 1'b0;
      r_rx_owner    <= OWN_DISP;
      r_tx_data     <= 8'h00;
      r_prog_loaded <= 1'b0;
      r_timeout     <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      r_state       <= w_state_next;
      r_start_load  <= w_start_load_next;
      r_start_run   <= w_start_run_next;
      r_start_step  <= w_start_step_next;
      r_abort       <= w_abort_next;
      r_tx_start    <= w_tx_start_next;
      r_rx_owner    <= w_rx_owner_next;
      r_tx_data     <= w_tx_data_next;
      r_prog_loaded <= w_prog_loaded_next;
      r_timeout     <= w_timeout_next;
      r_to_cnt      <= w_to_cnt_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_start_load_next  = 1'b0;
    w_start_run_next   = 1'b0;
    w_start_step_next  = 1'b0;
    w_abort_next       = 1'b0;
    w_tx_start_next    = 1'b0;
    w_rx_owner_next    = r_rx_owner;
    w_tx_data_next     = r_tx_data;
    w_prog_loaded_next = r_prog_loaded;
    w_timeout_next     = r_timeout;
    w_to_cnt_next      = r_to_cnt;

    case (r_state)
      S_IDLE: begin
        if (is_rx_done) begin
          if (i_rx_data == CMD_LOAD) begin
            w_start_load_next = 1'b1;
            w_rx_owner_next   = OWN_LOAD;
            w_timeout_next    = 1'b0;
            w_to_cnt_next     = '0;
            w_state_next      = S_WAIT_LOAD;
          end else if (i_rx_data == CMD_RUN && r_prog_loaded) begin
            w_start_run_next = 1'b1;
            w_rx_owner_next  = OWN_DISP;
            w_state_next     = S_WAIT_RUN;
          end else if (i_rx_data == CMD_STEP && r_prog_loaded) begin
            w_start_step_next = 1'b1;
            w_rx_owner_next   = OWN_STEP;
            w_state_next      = S_WAIT_STEP;
          end else begin
            w_tx_data_next = NAK_BYTE;
            w_state_next   = S_SEND;
          end
        end
      end

      S_WAIT_LOAD: begin
        // Completion has priority over a timeout expiring in the same cycle.
        if (is_load_done) begin
          w_prog_loaded_next = 1'b1;
          w_tx_data_next     = ACK_BYTE;
          w_rx_owner_next    = OWN_DISP;
          w_state_next       = S_SEND;
        end else if (is_rx_done) begin
          w_to_cnt_next = '0;
        end else if (r_to_cnt == TO_LAST) begin
          w_abort_next       = 1'b1;
          w_timeout_next     = 1'b1;
          w_prog_loaded_next = 1'b0;
          w_tx_data_next     = NAK_BYTE;
          w_rx_owner_next    = OWN_DISP;
          w_state_next       = S_SEND;
        end else begin
          w_to_cnt_next = r_to_cnt + CNT_ONE;
        end
      end

      S_WAIT_RUN: begin
        if (is_run_done) begin
          w_tx_data_next  = ACK_BYTE;
          w_rx_owner_next = OWN_DISP;
          w_state_next    = S_SEND;
        end
      end

      S_WAIT_STEP: begin
        if (is_step_done) begin
          w_tx_data_next  = ACK_BYTE;
          w_rx_owner_next = OWN_DISP;
          w_state_next    = S_SEND;
        end
      end

      S_SEND: begin
        w_tx_start_next = 1'b1;
        w_state_next    = S_WAIT_TX;
      end

      S_WAIT_TX: begin
        if (is_tx_done) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign os_start_load = r_start_load;
  assign os_start_run  = r_start_run;
  assign os_start_step = r_start_step;
  assign os_abort      = r_abort;
  assign os_tx_start   = r_tx_start;
  assign o_rx_owner    = r_rx_owner;
  assign o_tx_data     = r_tx_data;
  assign o_busy        = (r_state != S_IDLE);
  assign o_prog_loaded = r_prog_loaded;
  assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_debug_cmd_dispatcher.sv
// Randomized self-checking bench for debug_cmd_dispatcher; expected replies come from
// a command-level model of which commands are accepted given the loaded-program flag.
module tb_debug_cmd_dispatcher;

  localparam int TO_CYC = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] i_rx_data = 8'h00;
  logic       is_rx_done = 1'b0;
  logic       is_load_done = 1'b0;
  logic       is_run_done = 1'b0;
  logic       is_step_done = 1'b0;
  logic       is_tx_done = 1'b0;
  logic       os_start_load, os_start_run, os_start_step, os_abort, os_tx_start;
  logic [1:0] o_rx_owner;
  logic [7:0] o_tx_data;
  logic       o_busy, o_prog_loaded, o_timeout;

  int n_cmp = 0;
  int n_fail = 0;
  bit m_loaded = 1'b0;
  int cnt_start = 0;
  int cnt_abort = 0;
  int cnt_txs = 0;

  debug_cmd_dispatcher #(
    .TIMEOUT_CYCLES(TO_CYC),
    .TO_W(6)
  ) dut (
    .clk(clk), .rst(rst),
    .i_rx_data(i_rx_data), .is_rx_done(is_rx_done),
    .is_load_done(is_load_done), .is_run_done(is_run_done),
    .is_step_done(is_step_done), .is_tx_done(is_tx_done),
    .os_start_load(os_start_load), .os_start_run(os_start_run),
    .os_start_step(os_start_step), .os_abort(os_abort),
    .o_rx_owner(o_rx_owner), .os_tx_start(os_tx_start),
    .o_tx_data(o_tx_data), .o_busy(o_busy),
    .o_prog_loaded(o_prog_loaded), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  // Event tallies sampled on the falling edge, away from register updates.
  always @(negedge clk) begin
    if (os_start_load || os_start_run || os_start_step) cnt_start++;
    if (os_abort) cnt_abort++;
    if (os_tx_start) cnt_txs++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Command-level model: 0 = rejected, 1 = load, 2 = run, 3 = step.
  function automatic int model_kind(logic [7:0] b, bit loaded);
    if (b == 8'h4C) return 1;
    if (b == 8'h52 && loaded) return 2;
    if (b == 8'h53 && loaded) return 3;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    i_rx_data = b;
    is_rx_done = 1'b1;
    tick();
    is_rx_done = 1'b0;
  endtask

  task automatic pulse_in(input int which);
    is_load_done = (which == 0);
    is_run_done  = (which == 1);
    is_step_done = (which == 2);
    tick();
    is_load_done = 1'b0;
    is_run_done  = 1'b0;
    is_step_done = 1'b0;
  endtask

  // Observes the reply: cycles until os_tx_start, the byte, whether it stayed stable
  // while junk RX bytes arrive, then completes the TX and reports o_busy afterwards.
  task automatic wait_reply(output int lat, output logic [7:0] data,
                            output logic stable, output logic busy_after);
    lat = -1;
    data = 8'h00;
    stable = 1'b1;
    busy_after = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (os_tx_start) begin
        lat = c;
        break;
      end
      tick();
    end
    if (lat < 0) return;
    data = o_tx_data;
    repeat ($urandom_range(1, 4)) begin
      if ($urandom_range(0, 1) == 1) begin
        i_rx_data = 8'($urandom_range(0, 255));
        is_rx_done = 1'b1;
      end
      tick();
      is_rx_done = 1'b0;
      if (o_tx_data !== data) stable = 1'b0;
    end
    is_tx_done = 1'b1;
    tick();
    is_tx_done = 1'b0;
    busy_after = o_busy;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({os_start_load, os_start_run, os_start_step, os_abort, o_rx_owner, os_tx_start,
         o_tx_data, o_busy, o_prog_loaded, o_timeout} !== 18'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%0b tx=%0h owner=%0d loaded=%0b want all zero",
               o_busy, o_tx_data, o_rx_owner, o_prog_loaded);
    end
    rst = 1'b1;
    tick();
    m_loaded = 1'b0;
    $display("reset: outputs checked");
  endtask

  task automatic test_reject();
    logic [7:0] bytes [6];
    int lat, snap;
    logic [7:0] data;
    logic stable, busy_after;
    bytes[0] = 8'h52;
    bytes[1] = 8'h53;
    for (int i = 2; i < 6; i++) begin
      bytes[i] = 8'($urandom_range(0, 255));
      if (bytes[i] == 8'h4C) bytes[i] = 8'h00;
    end
    for (int i = 0; i < 6; i++) begin
      snap = cnt_start;
      send_rx(bytes[i]);
      wait_reply(lat, data, stable, busy_after);
      n_cmp++;
      if (lat !== 2 || data !== 8'hEE) begin
        n_fail++;
        $display("FAIL reject_reply: byte %0h got lat=%0d data=%0h want lat=2 data=ee",
                 bytes[i], lat, data);
      end
      n_cmp++;
      if (cnt_start - snap !== 0 || busy_after !== 1'b0 || stable !== 1'b1) begin
        n_fail++;
        $display("FAIL reject_side: byte %0h got starts=%0d busy=%0b stable=%0b want 0,0,1",
                 bytes[i], cnt_start - snap, busy_after, stable);
      end
      $display("reject: rx %0h -> tx %0h lat %0d", bytes[i], data, lat);
    end
  endtask

  task automatic test_load();
    int lat, snap;
    logic [7:0] data;
    logic stable, busy_after;
    send_rx(8'h4C);
    n_cmp++;
    if (os_start_load !== 1'b1 || o_rx_owner !== 2'd1) begin
      n_fail++;
      $display("FAIL load_start: got start=%0b owner=%0d want 1,1", os_start_load, o_rx_owner);
    end
    tick();
    n_cmp++;
    if (os_start_load !== 1'b0) begin
      n_fail++;
      $display("FAIL load_start_width: got %0b want 0", os_start_load);
    end
    snap = cnt_start;
    for (int i = 0; i < 40; i++) begin
      send_rx(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 3)) tick();
    end
    n_cmp++;
    if (cnt_start - snap !== 0 || o_rx_owner !== 2'd1 || os_abort !== 1'b0) begin
      n_fail++;
      $display("FAIL load_rx_routing: got starts=%0d owner=%0d want 0,1",
               cnt_start - snap, o_rx_owner);
    end
    pulse_in(0);
    n_cmp++;
    if (o_prog_loaded !== 1'b1 || o_rx_owner !== 2'd0) begin
      n_fail++;
      $display("FAIL load_done_flags: got loaded=%0b owner=%0d want 1,0", o_prog_loaded, o_rx_owner);
    end
    wait_reply(lat, data, stable, busy_after);
    n_cmp++;
    if (lat !== 2 || data !== 8'hAA || stable !== 1'b1 || busy_after !== 1'b0) begin
      n_fail++;
      $display("FAIL load_ack: got lat=%0d data=%0h stable=%0b busy=%0b want 2,aa,1,0",
               lat, data, stable, busy_after);
    end
    m_loaded = 1'b1;
    $display("load: 40 bytes routed, tx %0h lat %0d", data, lat);
  endtask

  task automatic test_step();
    int lat, snap_s, snap_t;
    logic [7:0] data;
    logic stable, busy_after;
    send_rx(8'h53);
    n_cmp++;
    if (os_start_step !== 1'b1 || o_rx_owner !== 2'd2) begin
      n_fail++;
      $display("FAIL step_start: got start=%0b owner=%0d want 1,2", os_start_step, o_rx_owner);
    end
    tick();
    snap_s = cnt_start;
    snap_t = cnt_txs;
    send_rx(8'h4C);
    pulse_in(1);
    repeat (4) tick();
    n_cmp++;
    if (cnt_start - snap_s !== 0 || cnt_txs - snap_t !== 0 || o_busy !== 1'b1 ||
        o_rx_owner !== 2'd2) begin
      n_fail++;
      $display("FAIL step_ignore: got starts=%0d txs=%0d busy=%0b owner=%0d want 0,0,1,2",
               cnt_start - snap_s, cnt_txs - snap_t, o_busy, o_rx_owner);
    end
    pulse_in(2);
    wait_reply(lat, data, stable, busy_after);
    n_cmp++;
    if (lat !== 2 || data !== 8'hAA || o_prog_loaded !== 1'b1) begin
      n_fail++;
      $display("FAIL step_ack: got lat=%0d data=%0h loaded=%0b want 2,aa,1",
               lat, data, o_prog_loaded);
    end
    $display("step: tx %0h lat %0d", data, lat);
  endtask

  task automatic test_timeout();
    int lat, snap_a, c_abort;
    logic [7:0] data;
    logic stable, busy_after;
    send_rx(8'h4C);
    snap_a = cnt_abort;
    repeat ($urandom_range(3, 5)) begin
      repeat (29) tick();
      send_rx(8'($urandom_range(0, 255)));
    end
    n_cmp++;
    if (cnt_abort - snap_a !== 0 || o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_keepalive: got aborts=%0d busy=%0b want 0,1",
               cnt_abort - snap_a, o_busy);
    end
    c_abort = -1;
    for (int c = 1; c <= TO_CYC + 10; c++) begin
      if (os_abort) begin
        c_abort = c;
        break;
      end
      tick();
    end
    n_cmp++;
    if (c_abort !== TO_CYC) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles want %0d", c_abort, TO_CYC);
    end
    n_cmp++;
    if (o_timeout !== 1'b1 || o_prog_loaded !== 1'b0 || o_tx_data !== 8'hEE ||
        o_rx_owner !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout_flags: got to=%0b loaded=%0b tx=%0h owner=%0d want 1,0,ee,0",
               o_timeout, o_prog_loaded, o_tx_data, o_rx_owner);
    end
    wait_reply(lat, data, stable, busy_after);
    n_cmp++;
    if (lat !== 2 || data !== 8'hEE || cnt_abort - snap_a !== 1) begin
      n_fail++;
      $display("FAIL timeout_nak: got lat=%0d data=%0h aborts=%0d want 2,ee,1",
               lat, data, cnt_abort - snap_a);
    end
    m_loaded = 1'b0;
    send_rx(8'h52);
    wait_reply(lat, data, stable, busy_after);
    n_cmp++;
    if (data !== 8'hEE || cnt_start != 0 && os_start_run !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_run_rejected: got data=%0h want ee", data);
    end
    $display("timeout: abort after %0d cycles, tx %0h", c_abort, data);
  endtask

  task automatic test_done_timeout_tie();
    int lat, snap_a;
    logic [7:0] data;
    logic stable, busy_after;
    snap_a = cnt_abort;
    send_rx(8'h4C);
    repeat (TO_CYC - 2) tick();
    pulse_in(0);
    n_cmp++;
    if (os_abort !== 1'b0 || o_prog_loaded !== 1'b1 || o_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_flags: got abort=%0b loaded=%0b to=%0b want 0,1,0",
               os_abort, o_prog_loaded, o_timeout);
    end
    wait_reply(lat, data, stable, busy_after);
    n_cmp++;
    if (data !== 8'hAA || cnt_abort - snap_a !== 0) begin
      n_fail++;
      $display("FAIL tie_ack: got data=%0h aborts=%0d want aa,0", data, cnt_abort - snap_a);
    end
    m_loaded = 1'b1;
    $display("tie: tx %0h", data);
  endtask

  task automatic test_reset_mid_run();
    int lat, snap_a;
    logic [7:0] data;
    logic stable, busy_after;
    snap_a = cnt_abort;
    send_rx(8'h52);
    n_cmp++;
    if (os_start_run !== 1'b1 || o_rx_owner !== 2'd0) begin
      n_fail++;
      $display("FAIL run_start: got start=%0b owner=%0d want 1,0", os_start_run, o_rx_owner);
    end
    repeat ($urandom_range(2, 6)) tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({os_start_load, os_start_run, os_start_step, os_abort, o_rx_owner, os_tx_start,
         o_tx_data, o_busy, o_prog_loaded, o_timeout} !== 18'h0 || cnt_abort - snap_a !== 0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got busy=%0b loaded=%0b tx=%0h aborts=%0d want zeros",
               o_busy, o_prog_loaded, o_tx_data, cnt_abort - snap_a);
    end
    rst = 1'b1;
    tick();
    m_loaded = 1'b0;
    send_rx(8'h52);
    wait_reply(lat, data, stable, busy_after);
    n_cmp++;
    if (lat !== 2 || data !== 8'hEE) begin
      n_fail++;
      $display("FAIL midreset_nak: got lat=%0d data=%0h want 2,ee", lat, data);
    end
    $display("midreset: run after reset -> tx %0h", data);
  endtask

  task automatic test_back_to_back();
    int lat, snap, kind, sel, foreign;
    logic [7:0] b, data, exp_byte;
    logic [1:0] exp_owner;
    logic [2:0] exp_start;
    logic stable, busy_after;
    for (int i = 0; i < 16; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: b = 8'h4C;
        1: b = 8'h52;
        2: b = 8'h53;
        default: begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'h4C) b = 8'h01;
        end
      endcase
      kind = model_kind(b, m_loaded);
      exp_start = (kind == 1) ? 3'b100 : (kind == 2) ? 3'b010 : (kind == 3) ? 3'b001 : 3'b000;
      exp_owner = (kind == 1) ? 2'd1 : (kind == 3) ? 2'd2 : 2'd0;
      exp_byte  = (kind == 0) ? 8'hEE : 8'hAA;
      snap = cnt_start;
      send_rx(b);
      n_cmp++;
      if ({os_start_load, os_start_run, os_start_step} !== exp_start) begin
        n_fail++;
        $display("FAIL b2b_start: rx %0h got %b want %b",
                 b, {os_start_load, os_start_run, os_start_step}, exp_start);
      end
      if (kind != 0) begin
        repeat ($urandom_range(0, 8)) begin
          sel = int'($urandom_range(0, 3));
          if (sel == 0) begin
            send_rx(8'($urandom_range(0, 255)));
          end else if (sel == 1) begin
            foreign = (kind + int'($urandom_range(0, 1))) % 3;
            pulse_in(foreign);
          end else begin
            tick();
          end
        end
        n_cmp++;
        if (o_rx_owner !== exp_owner || o_busy !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_owner: rx %0h got owner=%0d busy=%0b want %0d,1",
                   b, o_rx_owner, o_busy, exp_owner);
        end
        pulse_in(kind - 1);
        if (kind == 1) m_loaded = 1'b1;
      end
      wait_reply(lat, data, stable, busy_after);
      n_cmp++;
      if (lat !== 2 || data !== exp_byte || stable !== 1'b1 || busy_after !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_reply: rx %0h got lat=%0d data=%0h stable=%0b busy=%0b want 2,%0h,1,0",
                 b, lat, data, stable, busy_after, exp_byte);
      end
      n_cmp++;
      if (o_prog_loaded !== m_loaded || cnt_start - snap !== ((kind != 0) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL b2b_state: rx %0h got loaded=%0b starts=%0d want %0b,%0d",
                 b, o_prog_loaded, cnt_start - snap, m_loaded, (kind != 0) ? 1 : 0);
      end
      $display("b2b: rx %0h kind %0d -> tx %0h lat %0d", b, kind, data, lat);
    end
  endtask

  initial begin
    test_reset();
    test_reject();
    test_load();
    test_step();
    test_timeout();
    test_done_timeout_tie();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
